// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped 8N1 UART transmitter with a TX FIFO and a
// programmable bit period, answering loads combinationally.
module uart_tx_responder #(
    parameter int LENGTH = 32,
    parameter logic [LENGTH-1:0] BASE_ADDR = 32'h1000_0000,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LENGTH-1:0] HADDR,
    input  logic [LENGTH-1:0] HWDATA,
    input  logic              MemWrite,
    output logic [LENGTH-1:0] HRDATA,
    output logic              sel,
    output logic              tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state, state_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic overflow;
    logic [15:0] baud_div, frame_div, baud_cnt, eff_div;
    logic [2:0] bit_cnt;
    logic [7:0] shift, status;
    logic [1:0] idx;
    logic wr, full, empty, busy, push, accept, pop, tick, wr_status, wr_baud;
    logic unused_bits;

    assign idx = HADDR[3:2];
    assign sel = HADDR[LENGTH-1:4] == BASE_ADDR[LENGTH-1:4];
    assign wr = MemWrite & sel;
    assign push = wr & (idx == 2'd0);
    assign wr_status = wr & (idx == 2'd1);
    assign wr_baud = wr & (idx == 2'd2);
    assign full = count == DEPTH_C;
    assign empty = count == '0;
    assign busy = state != IDLE;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign accept = push & (~full | pop);
    assign eff_div = baud_div == 16'd0 ? 16'd1 : baud_div;
    assign tick = baud_cnt == frame_div - 16'd1;
    assign status = {4'(count), overflow, empty, full, busy};
    assign HRDATA = !sel ? '0 : idx == 2'd1 ? LENGTH'(status) : idx == 2'd2 ? LENGTH'(baud_div) : '0;
    assign unused_bits = ^{HWDATA[LENGTH-1:16], HADDR[1:0]};

    always_comb begin
        state_n = state;
        pop = 1'b0;
        tx = 1'b1;
        case (state)
            IDLE: begin
                pop = ~empty;
                state_n = empty ? IDLE : START;
            end
            START: begin
                tx = 1'b0;
                state_n = tick ? DATA : START;
            end
            DATA: begin
                tx = shift[0];
                state_n = (tick && bit_cnt == 3'd7) ? STOP : DATA;
            end
            STOP: begin
                pop = tick & ~empty;
                state_n = !tick ? STOP : empty ? IDLE : START;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            baud_div <= 16'(CLKS_PER_BIT);
            frame_div <= 16'd1;
            baud_cnt <= '0;
            bit_cnt <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
            overflow <= (push & full & ~pop) | (overflow & ~(wr_status & HWDATA[3]));
            if (wr_baud)
                baud_div <= HWDATA[15:0];
            if (accept) begin
                mem[wr_ptr] <= HWDATA[7:0];
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Each frame latches its own divisor so BAUDDIV writes only affect later frames
            if (pop) begin
                shift <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
                frame_div <= eff_div;
                baud_cnt <= '0;
                bit_cnt <= '0;
            end else if (busy) begin
                baud_cnt <= tick ? 16'd0 : baud_cnt + 16'd1;
                if (state == DATA && tick) begin
                    shift <= {1'b0, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end
endmodule
